// File: rtl/buzzer_scheduler.sv
// Buzzer arbitration for a clock: key clicks, hourly double-beep chime, and a
// timed alarm with snooze. All durations are in prescaled ticks.
module buzzer_scheduler #(
   parameter int TICK_DIV     = 500000,
   parameter int KEY_TICKS    = 5,
   parameter int CHIME_TICKS  = 10,
   parameter int ALM_TICKS    = 50,
   parameter int ALM_PERIODS  = 60,
   parameter int SNOOZE_TICKS = 30000,
   parameter int MAX_SNOOZE   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       alarm_req,
   input  logic       chime_req,
   input  logic       key_req,
   input  logic       stop_req,
   input  logic       snooze_req,
   output logic       buzz_en,
   output logic       alarm_active,
   output logic       snoozing,
   output logic [1:0] snooze_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_KEY, S_CHIME_ON, S_CHIME_GAP, S_ALM_ON, S_ALM_OFF, S_SNOOZE
   } state_t;

   localparam int MAX_A = (KEY_TICKS > CHIME_TICKS) ? KEY_TICKS : CHIME_TICKS;
   localparam int MAX_B = (ALM_TICKS > SNOOZE_TICKS) ? ALM_TICKS : SNOOZE_TICKS;
   localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TW    = $clog2(MAX_T + 1);
   localparam int CW    = $clog2(ALM_PERIODS + 1);

   state_t          state_reg, state_next;
   logic [PW-1:0]   pre_cnt_reg;
   logic [TW-1:0]   tick_cnt_reg;
   logic [TW-1:0]   tick_target;
   logic [CW-1:0]   period_cnt_reg, period_cnt_next;
   logic [1:0]      snooze_cnt_reg, snooze_cnt_next;
   logic            chime_second_reg, chime_second_next;
   logic            buzz_en_reg, buzz_en_next;
   logic            tick;
   logic            done;

   assign tick = (pre_cnt_reg == PW'(TICK_DIV - 1));

   always_comb begin
      tick_target = TW'(1);
      case (state_reg)
         S_KEY:                   tick_target = TW'(KEY_TICKS);
         S_CHIME_ON, S_CHIME_GAP: tick_target = TW'(CHIME_TICKS);
         S_ALM_ON, S_ALM_OFF:     tick_target = TW'(ALM_TICKS);
         S_SNOOZE:                tick_target = TW'(SNOOZE_TICKS);
         default:                 tick_target = TW'(1);
      endcase
   end

   assign done = tick && (tick_cnt_reg == tick_target - TW'(1));

   // State and timing registers; prescaler and tick count restart on every state change.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= S_IDLE;
         pre_cnt_reg      <= '0;
         tick_cnt_reg     <= '0;
         period_cnt_reg   <= '0;
         snooze_cnt_reg   <= '0;
         chime_second_reg <= 1'b0;
         buzz_en_reg      <= 1'b0;
      end else begin
         state_reg        <= state_next;
         period_cnt_reg   <= period_cnt_next;
         snooze_cnt_reg   <= snooze_cnt_next;
         chime_second_reg <= chime_second_next;
         buzz_en_reg      <= buzz_en_next;
         if (state_next != state_reg || state_reg == S_IDLE) begin
            pre_cnt_reg  <= '0;
            tick_cnt_reg <= '0;
         end else if (tick) begin
            pre_cnt_reg <= '0;
            if (tick_cnt_reg != TW'(MAX_T))
               tick_cnt_reg <= tick_cnt_reg + TW'(1);
         end else begin
            pre_cnt_reg <= pre_cnt_reg + PW'(1);
         end
      end
   end

   always_comb begin
      state_next        = state_reg;
      period_cnt_next   = period_cnt_reg;
      snooze_cnt_next   = snooze_cnt_reg;
      chime_second_next = chime_second_reg;
      case (state_reg)
         S_IDLE, S_KEY: begin
            if (alarm_req) begin
               state_next      = S_ALM_ON;
               period_cnt_next = '0;
            end else if (chime_req) begin
               state_next        = S_CHIME_ON;
               chime_second_next = 1'b0;
            end else if (state_reg == S_IDLE && key_req) begin
               state_next = S_KEY;
            end else if (state_reg == S_KEY && done) begin
               state_next = S_IDLE;
            end
         end
         S_CHIME_ON, S_CHIME_GAP: begin
            if (alarm_req) begin
               state_next      = S_ALM_ON;
               period_cnt_next = '0;
            end else if (done) begin
               if (state_reg == S_CHIME_GAP) begin
                  state_next        = S_CHIME_ON;
                  chime_second_next = 1'b1;
               end else if (chime_second_reg) begin
                  state_next = S_IDLE;
               end else begin
                  state_next = S_CHIME_GAP;
               end
            end
         end
         S_ALM_ON, S_ALM_OFF: begin
            if (stop_req) begin
               state_next = S_IDLE;
            end else if (snooze_req) begin
               if (snooze_cnt_reg < 2'(MAX_SNOOZE)) begin
                  state_next      = S_SNOOZE;
                  snooze_cnt_next = snooze_cnt_reg + 2'd1;
               end else begin
                  state_next = S_IDLE;
               end
            end else if (done) begin
               if (state_reg == S_ALM_ON) begin
                  state_next = S_ALM_OFF;
               end else if (period_cnt_reg >= CW'(ALM_PERIODS - 1)) begin
                  state_next = S_IDLE;
               end else begin
                  state_next      = S_ALM_ON;
                  period_cnt_next = period_cnt_reg + CW'(1);
               end
            end
         end
         S_SNOOZE: begin
            if (stop_req) begin
               state_next = S_IDLE;
            end else if (done) begin
               state_next      = S_ALM_ON;
               period_cnt_next = '0;
            end
         end
         default: state_next = S_IDLE;
      endcase
      // Every return to IDLE ends the current event, so its bookkeeping is dropped.
      if (state_next == S_IDLE) begin
         period_cnt_next   = '0;
         snooze_cnt_next   = '0;
         chime_second_next = 1'b0;
      end
   end

   always_comb begin
      buzz_en_next = (state_next == S_KEY) || (state_next == S_CHIME_ON) ||
                     (state_next == S_ALM_ON);
      alarm_active = (state_reg == S_ALM_ON) || (state_reg == S_ALM_OFF) ||
                     (state_reg == S_SNOOZE);
      snoozing     = (state_reg == S_SNOOZE);
   end

   assign buzz_en    = buzz_en_reg;
   assign snooze_cnt = snooze_cnt_reg;

endmodule

// File: doc/buzzer_scheduler.md
BUZZER_SCHEDULER -- requirements
Module: buzzer_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, clk cycles per tick (10 ms at 50 MHz).
REQ-002 SHALL have parameter KEY_TICKS, default 5, key-click on-time in ticks.
REQ-003 SHALL have parameter CHIME_TICKS, default 10, chime beep on-time and gap, in ticks.
REQ-004 SHALL have parameter ALM_TICKS, default 50, alarm beep on-time and off-time, in ticks.
REQ-005 SHALL have parameter ALM_PERIODS, default 60, alarm on/off periods before auto-timeout.
REQ-006 SHALL have parameter SNOOZE_TICKS, default 30000, snooze duration in ticks (5 min).
REQ-007 SHALL have parameter MAX_SNOOZE, default 3, maximum snoozes per alarm event.
REQ-008 SHALL have port clk, input, 1, 50 MHz system clock.
REQ-009 SHALL have port rst, input, 1; one clock; reset is synchronous and active-high.
REQ-010 SHALL have port alarm_req, input, 1, one-cycle pulse when the alarm time matches.
REQ-011 SHALL have port chime_req, input, 1, one-cycle pulse at the top of each hour.
REQ-012 SHALL have port key_req, input, 1, one-cycle pulse per debounced key press.
REQ-013 SHALL have port stop_req, input, 1, one-cycle pulse to dismiss the alarm.
REQ-014 SHALL have port snooze_req, input, 1, one-cycle pulse to snooze the alarm.
REQ-015 SHALL have port buzz_en, output, 1, registered enable to the tone generator's alarm_on input.
REQ-016 SHALL have port alarm_active, output, 1, high in ALM_ON, ALM_OFF and SNOOZE.
REQ-017 SHALL have port snoozing, output, 1, high only in SNOOZE.
REQ-018 SHALL have port snooze_cnt, output, 2, snoozes used in the current alarm event.

Function
REQ-019 SHALL implement states IDLE, KEY, CHIME_ON, CHIME_GAP, ALM_ON, ALM_OFF, SNOOZE.
REQ-020 SHALL restart the tick prescaler and tick counter on every state entry, so each state lasts exactly N*TICK_DIV cycles.
REQ-021 SHALL register buzz_en and assert it in KEY, CHIME_ON and ALM_ON only; it rises on the cycle after the request is sampled.
REQ-022 SHALL apply request priority alarm_req > chime_req > key_req when requests arrive in the same cycle.
REQ-023 IDLE: alarm_req->ALM_ON; else chime_req->CHIME_ON; else key_req->KEY.
REQ-024 KEY: after KEY_TICKS->IDLE; alarm_req->ALM_ON and chime_req->CHIME_ON preempt; key_req is ignored.
REQ-025 Chime sequence SHALL be CHIME_ON->CHIME_GAP->CHIME_ON->IDLE (two beeps); alarm_req preempts to ALM_ON; key_req and chime_req are ignored.
REQ-026 ALM_ON SHALL go to ALM_OFF after ALM_TICKS; ALM_OFF SHALL go to ALM_ON after ALM_TICKS and increment the period counter.
REQ-027 When the period counter reaches ALM_PERIODS at the end of ALM_OFF, the block SHALL enter IDLE (timeout).
REQ-028 In ALM_ON or ALM_OFF, stop_req SHALL go to IDLE on the next cycle and clear snooze_cnt.
REQ-029 In ALM_ON or ALM_OFF, snooze_req with snooze_cnt<MAX_SNOOZE SHALL enter SNOOZE and increment snooze_cnt.
REQ-030 In ALM_ON or ALM_OFF, snooze_req with snooze_cnt==MAX_SNOOZE SHALL act as stop_req.
REQ-031 When stop_req and snooze_req arrive in the same cycle, stop_req SHALL win.
REQ-032 SNOOZE: after SNOOZE_TICKS->ALM_ON with the period counter cleared; stop_req->IDLE.
REQ-033 Alarm states SHALL ignore alarm_req, chime_req and key_req; dropped requests are never queued.
REQ-034 stop_req and snooze_req SHALL have no effect outside alarm states.
REQ-035 Counters SHALL saturate or clear and never wrap; snooze_cnt SHALL clear on entry to IDLE from any alarm state.

Reset
REQ-036 rst high at a clk edge SHALL force IDLE with buzz_en=0, alarm_active=0, snoozing=0, snooze_cnt=0, and all counters 0; this takes priority over all requests, mid-sequence included.

Verification (TICK_DIV=4, KEY_TICKS=2, CHIME_TICKS=3, ALM_TICKS=2, ALM_PERIODS=3, SNOOZE_TICKS=5, MAX_SNOOZE=2)
REQ-037 key_req pulse in IDLE -> buzz_en high for exactly 8 cycles starting the next cycle, then IDLE.
REQ-038 chime_req -> buzz_en high 12, low 12, high 12 cycles; key_req mid-chime has no effect.
REQ-039 alarm_req with no stop -> 3 periods of 8 cycles high / 8 low, then IDLE with alarm_active=0 after 48 cycles.
REQ-040 Alarm, then snooze_req twice (each after resume) -> SNOOZE 20 cycles each with snooze_cnt 1 then 2; a third snooze_req -> IDLE with snooze_cnt=0.
REQ-041 key_req at cycle 3 of KEY then alarm_req -> ALM_ON next cycle; stop_req and snooze_req in the same cycle -> IDLE.
REQ-042 rst asserted in ALM_ON mid-tick -> all outputs 0 the next cycle; a key_req one cycle after release gives a full 8-cycle beep.
